// File: rtl/sr_exc_driver.sv
// Excitation driver for a WIDTH-bit SR flop bank: queues target words and turns each into s/r pulses.
// Optional `SR_VERIFY_EN adds q_fb / mismatch checking of the real bank against the mirror.
module sr_exc_driver #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int HOLD  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_q,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] q_mirror,
   output logic             busy,
   output logic [7:0]       set_cnt,
   output logic [7:0]       rst_cnt
`ifdef SR_VERIFY_EN
   ,
   input  logic [WIDTH-1:0] q_fb,
   output logic             mismatch
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRIVE, ST_SETTLE} state_t;

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp, r_rp;
   logic [AW:0]      r_cnt;
   logic [WIDTH-1:0] r_tgt, r_set_exc, r_rst_exc, r_q;
   logic [7:0]       r_set_cnt, r_rst_cnt;
   logic [HW-1:0]    r_hold;
   logic             w_full, w_empty, w_push, w_pop, w_last_settle;
   logic [WIDTH-1:0] w_head;

   function automatic logic [7:0] popcnt(input logic [WIDTH-1:0] v);
      logic [7:0] n;
      n = 8'd0;
      for (int i = 0; i < WIDTH; i++)
         if (v[i]) n = n + 8'd1;
      return n;
   endfunction

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] t;
      t = {1'b0, a} + {1'b0, b};
      return t[8] ? 8'hFF : t[7:0];
   endfunction

   assign w_full        = (r_cnt == (AW+1)'(DEPTH));
   assign w_empty       = (r_cnt == '0);
   assign w_push        = in_valid && !w_full;
   assign w_pop         = (r_state == ST_LOAD);
   assign w_head        = r_mem[r_rp];
   assign w_last_settle = (r_state == ST_SETTLE) && (r_hold == '0);

   assign in_ready = !w_full;
   assign busy     = (r_state != ST_IDLE) || !w_empty;
   assign s        = r_set_exc;
   assign r        = r_rst_exc;
   assign q_mirror = r_q;
   assign set_cnt  = r_set_cnt;
   assign rst_cnt  = r_rst_cnt;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (!w_empty) w_next = ST_LOAD;
         ST_LOAD:   w_next = ST_DRIVE;
         ST_DRIVE:  w_next = ST_SETTLE;
         ST_SETTLE: if (w_last_settle) w_next = w_empty ? ST_IDLE : ST_LOAD;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // FIFO payload and target word carry no reset; only control and visible outputs do.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= in_q;
      if (w_pop)  r_tgt <= w_head;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp      <= '0;
         r_rp      <= '0;
         r_cnt     <= '0;
         r_hold    <= '0;
         r_set_exc <= '0;
         r_rst_exc <= '0;
         r_q       <= '0;
         r_set_cnt <= 8'd0;
         r_rst_cnt <= 8'd0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         // Pulses are registered on the LOAD->DRIVE edge so they are visible exactly in DRIVE.
         r_set_exc <= '0;
         r_rst_exc <= '0;
         if (r_state == ST_LOAD) begin
            r_set_exc <= w_head & ~r_q;
            r_rst_exc <= ~w_head & r_q;
         end
         if (r_state == ST_DRIVE) begin
            r_q       <= r_tgt;
            r_set_cnt <= sat_add(r_set_cnt, popcnt(r_set_exc));
            r_rst_cnt <= sat_add(r_rst_cnt, popcnt(r_rst_exc));
            r_hold    <= HW'(HOLD - 1);
         end else if (r_state == ST_SETTLE && r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
         end
      end
   end

`ifdef SR_VERIFY_EN
   logic r_mismatch;
   assign mismatch = r_mismatch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  r_mismatch <= 1'b0;
      else if (w_last_settle && (q_fb != r_q))  r_mismatch <= 1'b1;
   end
`endif

   a_sr_exclusive: assert property (@(posedge clk) disable iff (rst) (r_set_exc & r_rst_exc) == '0);

endmodule

// File: tb/tb_sr_exc_driver.sv
// Scoreboard bench for sr_exc_driver: stimulus queues expected pulses, a negedge monitor checks them.
module tb_sr_exc_driver;
   localparam int W = 4;
   localparam int D = 4;
   localparam int H = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_q = '0;
   logic [W-1:0] s, r, q_mirror;
   logic         busy;
   logic [7:0]   set_cnt, rst_cnt;
`ifdef SR_VERIFY_EN
   logic [W-1:0] q_fb, bank;
   logic         mismatch;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit mon_en  = 1'b0;
   bit saw_full = 1'b0;

   typedef struct {
      logic [W-1:0] es;
      logic [W-1:0] er;
      logic [W-1:0] eq;
      int           sc;
      int           rc;
      int           gap;
   } exp_t;
   exp_t sb[$];

   sr_exc_driver #(.WIDTH(W), .DEPTH(D), .HOLD(H)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_q     (in_q),
      .s        (s),
      .r        (r),
      .q_mirror (q_mirror),
      .busy     (busy),
      .set_cnt  (set_cnt),
      .rst_cnt  (rst_cnt)
`ifdef SR_VERIFY_EN
      ,
      .q_fb     (q_fb),
      .mismatch (mismatch)
`endif
   );

`ifdef SR_VERIFY_EN
   // Flop bank model with bit 0 stuck at 0.
   always @(posedge clk or posedge rst) begin
      if (rst) bank <= '0;
      else     bank <= (bank & ~r) | s;
   end
   assign q_fb = bank & 4'b1110;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation on every visible pulse, then checks mirror/counters one cycle later.
   exp_t cur;
   int   last_pulse = -1;
   bit   pend = 1'b0;
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         chk("s_and_r_exclusive", 32'(s & r), 32'd0);
         if (pend) begin
            chk("q_mirror_after", 32'(q_mirror), 32'(cur.eq));
            chk("set_cnt_after", 32'(set_cnt), 32'(cur.sc));
            chk("rst_cnt_after", 32'(rst_cnt), 32'(cur.rc));
            pend = 1'b0;
         end
         if ((s | r) != '0) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_pulse: s=%b r=%b, expected no pulse", s, r);
            end else begin
               cur = sb.pop_front();
               chk("pulse_s", 32'(s), 32'(cur.es));
               chk("pulse_r", 32'(r), 32'(cur.er));
               if (cur.gap != 0) chk("pulse_gap", 32'(cyc - last_pulse), 32'(cur.gap));
               last_pulse = cyc;
               pend = 1'b1;
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] w);
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         saw_full = 1'b1;
         t++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_ready_timeout: in_ready=0, required 1");
      end
      in_valid = 1'b1;
      in_q     = w;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic issue(input logic [W-1:0] w, input logic [W-1:0] es, input logic [W-1:0] er,
                        input logic [W-1:0] eq, input int sc, input int rc, input int gap);
      exp_t e;
      e.es = es; e.er = er; e.eq = eq; e.sc = sc; e.rc = rc; e.gap = gap;
      sb.push_back(e);
      send(w);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (busy && t < 200) begin
         t++;
         @(negedge clk);
      end
      chk("idle_reached", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_s", 32'(s), 32'd0);
      chk("reset_r", 32'(r), 32'd0);
      chk("reset_q_mirror", 32'(q_mirror), 32'd0);
      chk("reset_set_cnt", 32'(set_cnt), 32'd0);
      chk("reset_rst_cnt", 32'(rst_cnt), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;

      // First word from reset, with latency check: LOAD after E+1, DRIVE after E+2.
      sb.push_back('{4'b1010, 4'b0000, 4'b1010, 2, 0, 0});
      send(4'b1010);
      @(posedge clk);
      #1 chk("latency_early_s", 32'(s), 32'd0);
      @(posedge clk);
      #1;
      chk("latency_s", 32'(s), 32'b1010);
      chk("latency_r", 32'(r), 32'b0000);
      wait_idle();

      issue(4'b0110, 4'b0100, 4'b1000, 4'b0110, 3, 1, 0);
      wait_idle();

      // Same word as the mirror: no pulse, counters hold.
      send(4'b0110);
      chk("same_word_busy", 32'(busy), 32'd1);
      wait_idle();
      chk("same_word_q", 32'(q_mirror), 32'b0110);
      chk("same_word_set_cnt", 32'(set_cnt), 32'd3);
      chk("same_word_rst_cnt", 32'(rst_cnt), 32'd1);
`ifdef SR_VERIFY_EN
      chk("mismatch_clear", 32'(mismatch), 32'd0);
`endif

      // Burst of six: FIFO fills, pulses drain in order HOLD+2 apart.
      saw_full = 1'b0;
      issue(4'b1111, 4'b1001, 4'b0000, 4'b1111,  5,  1, 0);
      issue(4'b0000, 4'b0000, 4'b1111, 4'b0000,  5,  5, H + 2);
      issue(4'b0101, 4'b0101, 4'b0000, 4'b0101,  7,  5, H + 2);
      issue(4'b1010, 4'b1010, 4'b0101, 4'b1010,  9,  7, H + 2);
      issue(4'b0011, 4'b0001, 4'b1000, 4'b0011, 10,  8, H + 2);
      issue(4'b1100, 4'b1100, 4'b0011, 4'b1100, 12, 10, H + 2);
      wait_idle();
      chk("burst_ready_dropped", 32'(saw_full), 32'd1);
      chk("burst_sb_drained", 32'(sb.size()), 32'd0);
      chk("burst_q_final", 32'(q_mirror), 32'b1100);
`ifdef SR_VERIFY_EN
      chk("mismatch_set", 32'(mismatch), 32'd1);
      repeat (3) @(negedge clk);
      chk("mismatch_sticky", 32'(mismatch), 32'd1);
`endif

      // Asynchronous reset in the middle of a pulse with a word still queued.
      mon_en = 1'b0;
      send(4'b1111);
      send(4'b0000);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_s", 32'(s), 32'd0);
      chk("midrst_r", 32'(r), 32'd0);
      chk("midrst_q_mirror", 32'(q_mirror), 32'd0);
      chk("midrst_set_cnt", 32'(set_cnt), 32'd0);
      chk("midrst_rst_cnt", 32'(rst_cnt), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
`ifdef SR_VERIFY_EN
      chk("midrst_mismatch", 32'(mismatch), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_busy", 32'(busy), 32'd0);
         chk("post_rst_no_pulse", 32'(s | r), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
